manchester_decoder: RTL
=======================

// Module: manchester_decoder
// PURPOSE
//  Sits between edge_detect and serial_decode. It turns the raw Manchester line into a
//  recovered NRZ bit stream plus a one-cycle bit strobe. It learns the bit period from
//  the alternating preamble, classifies every edge interval as short or long, and flags
//  code violations. It signals end-of-frame when the line goes quiet.
// PARAMETERS
//  CNT_WIDTH   12  width of the interval counter and of the bit-period register
//  MIN_PERIOD  8   smallest full-bit period (clocks) accepted during training
//  LOCK_EDGES  16  consecutive matching long intervals required to lock
// PORTS
//  clock         in   1          system clock
//  reset         in   1          asynchronous, active-high reset
//  pos_edge      in   1          rising-edge pulse from edge_detect
//  neg_edge      in   1          falling-edge pulse from edge_detect
//  serial_data   out  1          last decoded bit (rising mid-bit edge = 1)
//  bit_strobe    out  1          1-cycle pulse; serial_data is valid in that cycle
//  locked        out  1          high while in LOCKED
//  frame_end     out  1          1-cycle pulse on line-idle timeout while LOCKED
//  code_error    out  1          1-cycle pulse on a Manchester violation
//  bit_period    out  CNT_WIDTH  learned full-bit period P, in clocks
// BEHAVIOUR
//  Reset values
//   - All outputs 0; bit_period = 0.
//   - State = HUNT; counters = 0; phase = MID.
//  Interval counter cnt
//   - Increments every clock and saturates at all-ones.
//   - On an edge (exactly one of pos_edge/neg_edge), the interval I = cnt is captured
//     and cnt is reset to 1.
//  Simultaneous pos_edge & neg_edge
//   - Ignored as an edge.
//   - In LOCKED: pulse code_error and go to HUNT.
//  HUNT state
//   - Keeps prev = last I.
//   - An edge matches when I >= MIN_PERIOD and |I - prev| <= prev>>2. A match does
//     match_cnt++; a non-match sets match_cnt = 0.
//   - Every edge sets prev = I.
//   - When match_cnt reaches LOCK_EDGES: P <= I, bit_period <= I, go to LOCKED,
//     phase = MID. No strobe is issued for the locking edge.
//   - cnt saturating in HUNT clears match_cnt.
//  LOCKED state: each edge is classified with integer compares only
//   - GLITCH: I < P>>2. Pulse code_error, go to HUNT.
//   - SHORT: I < P - (P>>2).
//   - LONG: I <= P + (P>>2).
//  Transitions in LOCKED
//   - SHORT from MID -> phase BOUNDARY, no strobe.
//   - SHORT from BOUNDARY -> phase MID, strobe.
//   - LONG from MID -> MID, strobe.
//   - LONG from BOUNDARY -> code_error, go to HUNT.
//   - On strobe: serial_data = 1 for pos_edge, 0 for neg_edge.
//  Latency
//   - bit_strobe and serial_data update in the cycle after the edge pulse.
//   - serial_data holds until the next strobe.
//  Timeout
//   - In LOCKED, cnt > P + (P>>2) with no edge: pulse frame_end (once), go to HUNT.
//   - bit_period keeps its last value until the next lock.
//  Error recovery
//   - code_error and frame_end both leave via HUNT with match_cnt = 0.
//   - Retraining always needs LOCK_EDGES fresh matches.
//  Async reset mid-frame
//   - Returns immediately to the reset values; no frame_end is emitted.
// CONFIGURATION
//  MANCHESTER_BIT_COUNT_EN
//   - Defined: adds output bit_count [7:0].
//   - bit_count increments on each bit_strobe and saturates at 255.
//   - It is cleared on entry to LOCKED; it holds after frame_end until the next lock.
//   - Reset value 0.
//  Undefined
//   - Port and counter are absent; the rest of the behaviour is identical.
// TESTING
//  1. Reset; 16+ alternating-bit preamble at P=20 (edges every 20 clocks)
//     -> locked=1, bit_period=20, no strobes during training.
//  2. Locked at P=20; send bits 1,1,0 (short, short, long intervals)
//     -> three strobes, serial_data 1,1,0, each strobe 1 cycle after its edge.
//  3. Locked at P=20, phase BOUNDARY; a 20-clock interval arrives
//     -> code_error pulse, locked=0, no strobe.
//  4. Locked at P=20; line idle 26 clocks after the last mid-bit edge
//     -> single frame_end pulse at cnt=26, locked=0, bit_period stays 20.
//  5. Locked; 3-clock glitch pulse, then pos_edge & neg_edge together in one cycle
//     -> code_error on the glitch; the later dual edge in HUNT is ignored.
//  6. Assert reset mid-frame, then with MANCHESTER_BIT_COUNT_EN relock and send 300 bits
//     -> all outputs 0 immediately; bit_count saturates at 255.

Source files
------------

// File: rtl/manchester_decoder.sv
// ============================================================================
// manchester_decoder
//   Turns the edge pulses of a Manchester line into recovered NRZ bits and a
//   one-cycle bit strobe. It learns the bit period from the preamble and flags
//   code violations. Optional macro MANCHESTER_BIT_COUNT_EN adds a saturating
//   bit_count output.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module manchester_decoder #(
  parameter int CNT_WIDTH  = 12,
  parameter int MIN_PERIOD = 8,
  parameter int LOCK_EDGES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pos_edge,
  input  logic                 neg_edge,
  output logic                 serial_data,
  output logic                 bit_strobe,
  output logic                 locked,
  output logic                 frame_end,
  output logic                 code_error,
  output logic [CNT_WIDTH-1:0] bit_period
`ifdef MANCHESTER_BIT_COUNT_EN
  ,
  output logic [7:0]           bit_count
`endif
);

  localparam int MW = $clog2(LOCK_EDGES + 1);

  localparam logic [0:0] HUNT        = 1'b0;
  localparam logic [0:0] LOCKED      = 1'b1;
  localparam logic [0:0] PH_MID      = 1'b0;
  localparam logic [0:0] PH_BOUNDARY = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_P      = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [MW-1:0]        MATCH_LAST = MW'(LOCK_EDGES - 1);
  localparam logic [MW-1:0]        MATCH_ONE  = MW'(1);

  logic [0:0]           state_q, state_d;
  logic [0:0]           phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] prev_q, prev_d;
  logic [CNT_WIDTH-1:0] per_q, per_d;
  logic [MW-1:0]        match_q, match_d;
  logic                 sdata_q, sdata_d;
  logic                 strobe_q, strobe_d;
  logic                 ce_q, ce_d;
  logic                 fe_q, fe_d;

  logic                 w_single;
  logic                 w_dual;
  logic [CNT_WIDTH-1:0] w_diff;
  logic                 w_match;
  logic [CNT_WIDTH-1:0] w_short_lim;
  logic [CNT_WIDTH:0]   w_long_lim;
  logic                 w_glitch;
  logic                 w_short;
  logic                 w_long;
  logic                 w_timeout;

  assign w_single = pos_edge ^ neg_edge;
  assign w_dual   = pos_edge & neg_edge;

  // Training tolerance is a quarter of the previous interval, either direction.
  assign w_diff  = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
  assign w_match = (cnt_q >= MIN_P) && (w_diff <= (prev_q >> 2));

  // Upper limit carries an extra bit so P + P/4 never wraps.
  assign w_short_lim = per_q - (per_q >> 2);
  assign w_long_lim  = {1'b0, per_q} + {3'b000, per_q[CNT_WIDTH-1:2]};
  assign w_glitch    = cnt_q < (per_q >> 2);
  assign w_short     = cnt_q < w_short_lim;
  assign w_long      = {1'b0, cnt_q} <= w_long_lim;
  assign w_timeout   = {1'b0, cnt_q} > w_long_lim;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    prev_d   = prev_q;
    match_d  = match_q;
    per_d    = per_q;
    sdata_d  = sdata_q;
    strobe_d = 1'b0;
    ce_d     = 1'b0;
    fe_d     = 1'b0;
    if (w_single)
      cnt_d = CNT_ONE;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_ONE;

    case (state_q)
      HUNT: begin
        if (w_single) begin
          prev_d = cnt_q;
          if (!w_match) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            per_d   = cnt_q;
            phase_d = PH_MID;
            match_d = '0;
          end else begin
            match_d = match_q + MATCH_ONE;
          end
        end else if (cnt_q == CNT_MAX) begin
          match_d = '0;
        end
      end
      default: begin
        if (w_dual) begin
          ce_d = 1'b1;
        end else if (w_single) begin
          if (w_glitch || !w_long) begin
            ce_d = 1'b1;
          end else if (w_short) begin
            if (phase_q == PH_MID) begin
              phase_d = PH_BOUNDARY;
            end else begin
              phase_d  = PH_MID;
              strobe_d = 1'b1;
            end
          end else if (phase_q == PH_MID) begin
            strobe_d = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
        end else if (w_timeout) begin
          fe_d = 1'b1;
        end
        if (strobe_d)
          sdata_d = pos_edge;
        if (ce_d || fe_d) begin
          state_d = HUNT;
          phase_d = PH_MID;
          match_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      phase_q  <= PH_MID;
      cnt_q    <= '0;
      prev_q   <= '0;
      per_q    <= '0;
      match_q  <= '0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
      ce_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      per_q    <= per_d;
      match_q  <= match_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
      ce_q     <= ce_d;
      fe_q     <= fe_d;
    end
  end

  assign serial_data = sdata_q;
  assign bit_strobe  = strobe_q;
  assign locked      = (state_q == LOCKED);
  assign frame_end   = fe_q;
  assign code_error  = ce_q;
  assign bit_period  = per_q;

`ifdef MANCHESTER_BIT_COUNT_EN
  logic [7:0] bcnt_q, bcnt_d;
  logic       w_lock_now;

  assign w_lock_now = (state_q == HUNT) && (state_d == LOCKED);

  always_comb begin
    bcnt_d = bcnt_q;
    if (w_lock_now)
      bcnt_d = '0;
    else if (strobe_d && (bcnt_q != 8'hFF))
      bcnt_d = bcnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      bcnt_q <= '0;
    else
      bcnt_q <= bcnt_d;
  end

  assign bit_count = bcnt_q;
`endif

endmodule

`default_nettype wire
